sequence_checker: RTL
=====================

Name: sequence_checker

Overview:
- Game-control stage directly downstream of the player's 4-bit guess load register.
- Generates a pseudo-random digit sequence, presents it digit-by-digit to the display, then checks each guess the register produces against the sequence.
- Tracks score and lives, and declares game over when lives are exhausted.
- Outputs feed the display/LED stage.

Parameters:
- SEQ_LEN, 4, digits per round (2..8).
- SHOW_CYCLES, 8, clock cycles each digit is presented (>=1).
- LIVES, 3, lives at game start (1..3).
- SEED, 4'b1001, LFSR seed after reset (must be nonzero).
- TIMEOUT_CYCLES, 64, guess timeout; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- enable  input  1  player logged in; low forces the block to IDLE.
- logout  input  1  synchronous clear to IDLE.
- start  input  1  level; begins a game from IDLE or OVER.
- guess_valid  input  1  one-cycle pulse when a new guess is loaded.
- guess  input  4  registered guess value.
- show_digit  output  4  digit under presentation; 0 when not showing.
- show_valid  output  1  high while in SHOW.
- digit_idx  output  3  current position in the sequence.
- correct  output  1  one-cycle pulse on a matching guess.
- wrong  output  1  one-cycle pulse on a mismatch (or on timeout).
- score  output  8  rounds completed; saturates at 255.
- lives  output  2  lives remaining.
- game_over  output  1  high in OVER.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, lfsr=SEED, replay=SEED.
  - digit_idx=0, score=0, lives=LIVES.
  - show_digit, show_valid, correct, wrong, game_over all 0.
- Priority: rst > logout/!enable > state logic.
- logout=1 or enable=0 (sync): next cycle state=IDLE, score=0, lives=LIVES, idx=0, pulses 0. lfsr is retained.
- LFSR step: lfsr <= {lfsr[2:0], lfsr[3]^lfsr[2]}. The value 0 never occurs, so a guess of 0 is always wrong.
- IDLE:
  - start=1 -> SHOW with replay<=lfsr, idx=0.
  - guess_valid is ignored.
- SHOW:
  - show_valid=1, show_digit=lfsr, held for SHOW_CYCLES cycles.
  - After each digit: step lfsr, idx++.
  - After digit SEQ_LEN-1: lfsr<=replay, idx=0, go to GUESS.
  - guess_valid during SHOW is ignored (no pulse).
- GUESS, on guess_valid:
  - Match (guess==lfsr):
    - correct=1 next cycle; step lfsr; idx++.
    - If idx was SEQ_LEN-1: score++ (saturating), replay<=stepped lfsr, idx=0, go to SHOW with a new sequence.
  - Mismatch:
    - wrong=1 next cycle; lives--.
    - If lives becomes 0: go to OVER.
    - Otherwise: lfsr<=replay, idx=0, go to SHOW and replay the same sequence.
- OVER:
  - game_over=1; score held for display.
  - start=1 -> score=0, lives=LIVES, replay<=lfsr, go to SHOW.
- Pulse outputs last exactly one cycle. guess_valid held high counts once per assertion in GUESS (edge-qualified internally).
- Latency: guess_valid -> correct/wrong is exactly 1 cycle.
- The state change out of SHOW and the first GUESS check cannot happen in the same cycle.

Optional Feature:
- Macro: SEQ_CHECK_TIMEOUT_EN.
- Defined:
  - A counter runs while in GUESS and restarts on each guess_valid.
  - Reaching TIMEOUT_CYCLES with no guess is treated as a mismatch: wrong pulse, lives--, and the same transitions as a wrong guess.
- Undefined: no counter; GUESS waits indefinitely.

Decomposition:
- Package memgame_pkg holds:
  - state enum: IDLE, SHOW, GUESS, OVER.
  - LFSR tap constant and next-value function.
  - DIGIT_W=4.
- Sub-module lfsr4 (load, step, 4-bit state): natural reuse for replay/restore.

Test Plan:
- Reset, start=1 -> show_digit 9,3,6,13, each for 8 cycles, show_valid high; then GUESS.
- Guesses 9,3,6,13 -> four correct pulses, score=1, next SHOW begins with 10.
- Guesses 9,5 -> correct then wrong, lives=2, SHOW replays 9,3,6,13.
- Three wrong guesses across rounds -> lives=0, game_over=1; start -> score=0, lives=3.
- guess_valid during SHOW -> no pulse, no state change; logout mid-GUESS -> IDLE next cycle, score=0.
- With SEQ_CHECK_TIMEOUT_EN, idle for 64 cycles in GUESS -> wrong pulse, lives 3->2.

Source files
------------

// File: rtl/memgame_pkg.sv
// Shared types and LFSR helpers for the memory-game sequence checker.
package memgame_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_GUESS = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Feedback taps on bits 3 and 2; shifting left keeps the register nonzero.
  localparam logic [DIGIT_W-1:0] LFSR_TAPS = 4'b1100;

  function automatic logic [DIGIT_W-1:0] lfsr_next(input logic [DIGIT_W-1:0] v);
    return {v[DIGIT_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sequence_checker_lfsr4.sv
// 4-bit LFSR register with load (priority) and step controls.
module lfsr4
  import memgame_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] SEED = 4'b1001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               step_i,
  output logic [DIGIT_W-1:0] value_o
);

  logic [DIGIT_W-1:0] value_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= SEED;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (step_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sequence_checker.sv
// Memory-game control: shows an LFSR digit sequence, checks guesses, tracks score/lives.
// Optional guess timeout enabled by defining SEQ_CHECK_TIMEOUT_EN.
module sequence_checker
  import memgame_pkg::*;
#(
  parameter int                 SEQ_LEN        = 4,
  parameter int                 SHOW_CYCLES    = 8,
  parameter int                 LIVES          = 3,
  parameter logic [DIGIT_W-1:0] SEED           = 4'b1001,
  parameter int                 TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               logout,
  input  logic               start,
  input  logic               guess_valid,
  input  logic [DIGIT_W-1:0] guess,
  output logic [DIGIT_W-1:0] show_digit,
  output logic               show_valid,
  output logic [2:0]         digit_idx,
  output logic               correct,
  output logic               wrong,
  output logic [7:0]         score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int             SC_W       = $clog2(SHOW_CYCLES + 1);
  localparam logic [2:0]     LAST_IDX   = 3'(SEQ_LEN - 1);
  localparam logic [SC_W-1:0] SHOW_LAST = SC_W'(SHOW_CYCLES - 1);
  localparam logic [1:0]     LIVES_INIT = 2'(LIVES);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [SC_W-1:0]    show_cnt_q, show_cnt_d;
  logic [7:0]         score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic               correct_q, correct_d;
  logic               wrong_q, wrong_d;
  logic               gv_prev_q;

  logic [DIGIT_W-1:0] lfsr, replay;
  logic               lfsr_load, lfsr_step, replay_load;
  logic [DIGIT_W-1:0] lfsr_load_val, replay_load_val;
  logic               guess_rise;
  logic               timeout;

  assign guess_rise = guess_valid & ~gv_prev_q;

  lfsr4 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_load_val),
    .step_i     (lfsr_step),
    .value_o    (lfsr)
  );

  // Replay holds the first digit of the current round; it is only ever loaded.
  lfsr4 #(.SEED(SEED)) u_replay (
    .clk        (clk),
    .rst        (rst),
    .load_i     (replay_load),
    .load_val_i (replay_load_val),
    .step_i     (1'b0),
    .value_o    (replay)
  );

`ifdef SEQ_CHECK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign timeout = (state_q == ST_GUESS) && !guess_rise && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_GUESS || guess_rise || timeout || logout || !enable) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    show_cnt_d      = show_cnt_q;
    score_d         = score_q;
    lives_d         = lives_q;
    correct_d       = 1'b0;
    wrong_d         = 1'b0;
    lfsr_load       = 1'b0;
    lfsr_load_val   = replay;
    lfsr_step       = 1'b0;
    replay_load     = 1'b0;
    replay_load_val = lfsr;
    if (logout || !enable) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      show_cnt_d = '0;
      score_d    = '0;
      lives_d    = LIVES_INIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_SHOW;
            replay_load = 1'b1;
            idx_d       = '0;
            show_cnt_d  = '0;
          end
        end
        ST_SHOW: begin
          if (show_cnt_q == SHOW_LAST) begin
            show_cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              lfsr_load = 1'b1;
              idx_d     = '0;
              state_d   = ST_GUESS;
            end else begin
              lfsr_step = 1'b1;
              idx_d     = idx_q + 3'd1;
            end
          end else begin
            show_cnt_d = show_cnt_q + SC_W'(1);
          end
        end
        ST_GUESS: begin
          if (guess_rise && guess == lfsr) begin
            correct_d = 1'b1;
            lfsr_step = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d           = '0;
              score_d         = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              replay_load     = 1'b1;
              replay_load_val = lfsr_next(lfsr);
              show_cnt_d      = '0;
              state_d         = ST_SHOW;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else if (guess_rise || timeout) begin
            // On the final life the LFSR is left where it is, so a restart begins a fresh sequence.
            wrong_d    = 1'b1;
            lives_d    = lives_q - 2'd1;
            idx_d      = '0;
            show_cnt_d = '0;
            if (lives_q == 2'd1) begin
              state_d = ST_OVER;
            end else begin
              lfsr_load = 1'b1;
              state_d   = ST_SHOW;
            end
          end
        end
        ST_OVER: begin
          if (start) begin
            score_d     = '0;
            lives_d     = LIVES_INIT;
            replay_load = 1'b1;
            idx_d       = '0;
            show_cnt_d  = '0;
            state_d     = ST_SHOW;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      show_cnt_q <= '0;
      score_q    <= '0;
      lives_q    <= LIVES_INIT;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      gv_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      show_cnt_q <= show_cnt_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      gv_prev_q  <= guess_valid;
    end
  end

  assign show_valid = (state_q == ST_SHOW);
  assign show_digit = show_valid ? lfsr : '0;
  assign digit_idx  = idx_q;
  assign correct    = correct_q;
  assign wrong      = wrong_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == ST_OVER);

endmodule
